// File: rtl/cci_mpf_csr_event_counters_if.sv
// Indexed read port between the CSR manager's MMIO read path and the VTP
// event counter block.
//   rd_req        request valid, one request accepted per cycle
//   rd_idx        counter index for the request
//   rd_rsp_valid  response valid, two cycles after the request
//   rd_rsp_data   counter value captured in the request cycle
// master: CSR manager side; slave: counter block side.
interface cci_mpf_csr_event_counters_if #(
   parameter int IDX_WIDTH     = 3,
   parameter int COUNTER_WIDTH = 64
);
   logic                     rd_req;
   logic [IDX_WIDTH-1:0]     rd_idx;
   logic                     rd_rsp_valid;
   logic [COUNTER_WIDTH-1:0] rd_rsp_data;

   modport master (
      output rd_req,
      output rd_idx,
      input  rd_rsp_valid,
      input  rd_rsp_data
   );

   modport slave (
      input  rd_req,
      input  rd_idx,
      output rd_rsp_valid,
      output rd_rsp_data
   );
endinterface

// File: rtl/cci_mpf_csr_event_counters.sv
// VTP event counters for the MPF CSR block. Single-cycle event pulses are
// registered, then summed into free-running modulo-2^COUNTER_WIDTH counters.
// Counters are read through a two-stage pipelined indexed port.
//   clk      sole clock
//   reset_n  asynchronous active-low reset
//   events   one pulse bit per event (4kb_hit, 4kb_miss, 2mb_hit, 2mb_miss,
//            pt_walk_busy)
//   freeze   level; while high, incoming events are discarded
//   clear    single-cycle pulse zeroing all counters
//   rd       read port (slave side), see cci_mpf_csr_event_counters_if
// The read interface instance must use the same IDX_WIDTH/COUNTER_WIDTH,
// and 2^IDX_WIDTH must be >= N_EVENTS.
module cci_mpf_csr_event_counters #(
   parameter int N_EVENTS      = 5,
   parameter int COUNTER_WIDTH = 64,
   parameter int IDX_WIDTH     = 3
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [N_EVENTS-1:0]           events,
   input  logic                          freeze,
   input  logic                          clear,
   cci_mpf_csr_event_counters_if.slave   rd
);

   logic [N_EVENTS-1:0]      event_q;
   logic [COUNTER_WIDTH-1:0] counter [N_EVENTS];
   logic [COUNTER_WIDTH-1:0] rd_mux;
   logic                     rd_a_valid;
   logic [COUNTER_WIDTH-1:0] rd_a_data;

   // Clear also drops the registered events so nothing from before the
   // clear can land afterwards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         event_q <= '0;
      end else if (clear) begin
         event_q <= '0;
      end else begin
         event_q <= events & ~{N_EVENTS{freeze}};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_EVENTS; i++) begin
            counter[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_EVENTS; i++) begin
            if (clear) begin
               counter[i] <= '0;
            end else begin
               counter[i] <= counter[i] + COUNTER_WIDTH'(event_q[i]);
            end
         end
      end
   end

   // Unmatched (out-of-range) indices fall through to zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_EVENTS; i++) begin
         if (rd.rd_idx == IDX_WIDTH'(i)) begin
            rd_mux = counter[i];
         end
      end
   end

   // Stage A samples the pre-edge counter value; data holds when idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_a_valid <= 1'b0;
         rd_a_data  <= '0;
      end else begin
         rd_a_valid <= rd.rd_req;
         if (rd.rd_req) begin
            rd_a_data <= rd_mux;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd.rd_rsp_valid <= 1'b0;
         rd.rd_rsp_data  <= '0;
      end else begin
         rd.rd_rsp_valid <= rd_a_valid;
         rd.rd_rsp_data  <= rd_a_data;
      end
   end

endmodule

// File: tb/tb_cci_mpf_csr_event_counters.sv
module tb_cci_mpf_csr_event_counters;

   localparam int N  = 5;
   localparam int CW = 8;   // narrow counters so wrap-around is reachable
   localparam int IW = 3;

   logic          clk;
   logic          reset_n;
   logic [N-1:0]  events;
   logic          freeze;
   logic          clear;

   cci_mpf_csr_event_counters_if #(.IDX_WIDTH(IW), .COUNTER_WIDTH(CW)) bus ();

   cci_mpf_csr_event_counters #(
      .N_EVENTS(N), .COUNTER_WIDTH(CW), .IDX_WIDTH(IW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .events  (events),
      .freeze  (freeze),
      .clear   (clear),
      .rd      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            due;
      logic [CW-1:0] data;
   } rd_t;

   // Reference model: per-cycle history of accepted events and clears.
   // The counter seen in cycle t is the number of accepted events in cycles
   // after the last clear before t, up to t-2, modulo 2^CW.
   logic [N-1:0] hist [$];
   bit           clrs [$];
   rd_t          rq   [$];
   int           cyc;
   int           checks;
   int           failures;

   function automatic logic [CW-1:0] model_read(input int idx, input int t);
      int     lo;
      longint sum;
      lo  = 0;
      sum = 0;
      if (idx >= N) return '0;
      for (int s = 0; s < t; s++) if (clrs[s]) lo = s + 1;
      for (int s = lo; s <= t - 2; s++) sum += longint'(hist[s][idx]);
      return CW'(sum);
   endfunction

   task automatic check_outputs();
      bit exp_v;
      exp_v = (rq.size() > 0) && (rq[0].due == cyc);
      checks++;
      assert (bus.rd_rsp_valid === exp_v) else begin
         failures++;
         $error("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rd_rsp_valid, exp_v);
      end
      if (exp_v) begin
         checks++;
         assert (bus.rd_rsp_data === rq[0].data) else begin
            failures++;
            $error("FAIL rsp_data cyc=%0d got=%0d exp=%0d", cyc, bus.rd_rsp_data, rq[0].data);
         end
         void'(rq.pop_front());
      end
   endtask

   task automatic step(input logic [N-1:0] ev, input logic frz, input logic clr,
                       input logic req, input logic [IW-1:0] idx);
      rd_t r;
      events     = ev;
      freeze     = frz;
      clear      = clr;
      bus.rd_req = req;
      bus.rd_idx = idx;
      if (req) begin
         r.due  = cyc + 2;
         r.data = model_read(int'(idx), cyc);
         rq.push_back(r);
      end
      hist.push_back(frz ? '0 : ev);
      clrs.push_back(clr);
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic rd(input int idx);
      step('0, 1'b0, 1'b0, 1'b1, IW'(idx));
   endtask

   task automatic model_reset();
      hist.delete();
      clrs.delete();
      rq.delete();
      cyc = 0;
   endtask

   // Asserts reset away from a clock edge, checks the outputs drop at once,
   // then releases on a falling edge so the next rising edge is cycle 0.
   task automatic do_reset();
      events     = '0;
      freeze     = 1'b0;
      clear      = 1'b0;
      bus.rd_req = 1'b0;
      bus.rd_idx = '0;
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      assert (bus.rd_rsp_valid === 1'b0) else begin
         failures++;
         $error("FAIL reset_valid got=%b exp=0", bus.rd_rsp_valid);
      end
      checks++;
      assert (bus.rd_rsp_data === '0) else begin
         failures++;
         $error("FAIL reset_data got=%0d exp=0", bus.rd_rsp_data);
      end
      @(posedge clk);
      #1;
      checks++;
      assert (bus.rd_rsp_valid === 1'b0) else begin
         failures++;
         $error("FAIL reset_hold_valid got=%b exp=0", bus.rd_rsp_valid);
      end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      reset_n  = 1'b0;
      events   = '0;
      freeze   = 1'b0;
      clear    = 1'b0;
      bus.rd_req = 1'b0;
      bus.rd_idx = '0;
      repeat (3) @(posedge clk);
      #1;
      do_reset();

      // reset then idle: all counters zero
      for (int i = 0; i < N; i++) rd(i);
      idle(3);

      // counting
      for (int i = 0; i < 10; i++) step(5'b00001, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 3; i++)  step(5'b10000, 1'b0, 1'b0, 1'b0, '0);
      idle(2);
      for (int i = 0; i < N; i++) rd(i);
      idle(2);

      // event-to-count latency
      step(5'b00100, 1'b0, 1'b0, 1'b0, '0);
      rd(2);
      rd(2);
      idle(2);

      // clear with simultaneous event and read
      step('0, 1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 8; i++) step(5'b00001, 1'b0, 1'b0, 1'b0, '0);
      step(5'b00001, 1'b0, 1'b1, 1'b1, 3'd0);
      step(5'b00001, 1'b0, 1'b0, 1'b1, 3'd0);
      idle(1);
      rd(0);
      idle(2);

      // wrap: 2^CW + 3 events on idx 1
      step('0, 1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < (1 << CW) + 3; i++) step(5'b00010, 1'b0, 1'b0, 1'b0, '0);
      idle(2);
      rd(1);
      idle(2);

      // freeze: one event already in flight still lands
      step(5'b00010, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 5; i++) step(5'b00010, 1'b1, 1'b0, 1'b1, 3'd1);
      idle(2);
      rd(1);
      idle(2);

      // clear while frozen
      step(5'b11111, 1'b1, 1'b1, 1'b0, '0);
      for (int i = 0; i < N; i++) rd(i);
      idle(2);

      // out-of-range indices
      step(5'b11111, 1'b0, 1'b0, 1'b0, '0);
      idle(2);
      rd(5);
      rd(6);
      rd(7);
      idle(2);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(N'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0),
              1'($urandom_range(0, 1)), IW'($urandom_range(0, 7)));
      end
      idle(2);

      // async reset with two reads in flight
      step(5'b11111, 1'b0, 1'b0, 1'b1, 3'd0);
      step(5'b11111, 1'b0, 1'b0, 1'b1, 3'd4);
      do_reset();
      idle(4);
      for (int i = 0; i < N; i++) rd(i);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
